// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM encoding,
// per-stage control bundles and the canned control patterns the FSM selects from.
package pipe_ctrl_pkg;

    localparam int REG_W                = 5;
    localparam int PC_W                 = 32;
    localparam int DRAIN_CYCLES_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_MEM_WAIT  = 2'd1,
        ST_DIV_WAIT  = 2'd2,
        ST_EXC_DRAIN = 2'd3
    } ctrl_state_e;

    typedef struct packed {
        logic wen;
        logic flush;
    } stage_ctl_t;

    typedef struct packed {
        logic            pc_wen;
        stage_ctl_t      if_id;
        stage_ctl_t      id_ex;
        logic            id_ex_bp_flush;
        stage_ctl_t      ex_mem;
        stage_ctl_t      mem_wb;
        logic            redirect_valid;
        logic [PC_W-1:0] redirect_pc;
    } ctrl_out_t;

    localparam stage_ctl_t STAGE_RUN    = '{wen: 1'b1, flush: 1'b0};
    localparam stage_ctl_t STAGE_HOLD   = '{wen: 1'b0, flush: 1'b0};
    localparam stage_ctl_t STAGE_BUBBLE = '{wen: 1'b1, flush: 1'b1};

    // All-zero bundle: used both while in reset and for a full pipeline freeze.
    localparam ctrl_out_t CTL_IDLE = '0;

    localparam ctrl_out_t CTL_RUN = '{
        pc_wen: 1'b1, if_id: STAGE_RUN, id_ex: STAGE_RUN, id_ex_bp_flush: 1'b0,
        ex_mem: STAGE_RUN, mem_wb: STAGE_RUN, redirect_valid: 1'b0, redirect_pc: '0};

    localparam ctrl_out_t CTL_DIV = '{
        pc_wen: 1'b0, if_id: STAGE_HOLD, id_ex: STAGE_HOLD, id_ex_bp_flush: 1'b0,
        ex_mem: STAGE_HOLD, mem_wb: STAGE_BUBBLE, redirect_valid: 1'b0, redirect_pc: '0};

    localparam ctrl_out_t CTL_LOAD_USE = '{
        pc_wen: 1'b0, if_id: STAGE_HOLD, id_ex: STAGE_BUBBLE, id_ex_bp_flush: 1'b0,
        ex_mem: STAGE_RUN, mem_wb: STAGE_RUN, redirect_valid: 1'b0, redirect_pc: '0};

    localparam ctrl_out_t CTL_MISPREDICT = '{
        pc_wen: 1'b1, if_id: STAGE_BUBBLE, id_ex: STAGE_BUBBLE, id_ex_bp_flush: 1'b1,
        ex_mem: STAGE_RUN, mem_wb: STAGE_RUN, redirect_valid: 1'b0, redirect_pc: '0};

    localparam ctrl_out_t CTL_EXC = '{
        pc_wen: 1'b1, if_id: STAGE_BUBBLE, id_ex: STAGE_BUBBLE, id_ex_bp_flush: 1'b0,
        ex_mem: STAGE_BUBBLE, mem_wb: STAGE_BUBBLE, redirect_valid: 1'b0, redirect_pc: '0};

    localparam ctrl_out_t CTL_DRAIN = '{
        pc_wen: 1'b1, if_id: STAGE_BUBBLE, id_ex: STAGE_RUN, id_ex_bp_flush: 1'b0,
        ex_mem: STAGE_RUN, mem_wb: STAGE_RUN, redirect_valid: 1'b0, redirect_pc: '0};

    function automatic ctrl_out_t with_redirect(ctrl_out_t base, logic [PC_W-1:0] pc);
        ctrl_out_t r;
        r                = base;
        r.redirect_valid = 1'b1;
        r.redirect_pc    = pc;
        return r;
    endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Load-use hazard detector: the instruction in ID reads a register that the
// load currently in EX has not yet produced.
module pipe_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic             ex_is_load_i,
    input  logic [REG_W-1:0] ex_reg_d_i,
    input  logic [REG_W-1:0] id_reg_j_i,
    input  logic [REG_W-1:0] id_reg_k_i,
    input  logic [REG_W-1:0] id_reg_d_i,
    input  logic             id_reg_j_ren_i,
    input  logic             id_reg_k_ren_i,
    input  logic             id_reg_d_ren_i,
    output logic             load_use_o
);

    logic hit_j;
    logic hit_k;
    logic hit_d;

    assign hit_j = id_reg_j_ren_i && (id_reg_j_i == ex_reg_d_i);
    assign hit_k = id_reg_k_ren_i && (id_reg_k_i == ex_reg_d_i);
    assign hit_d = id_reg_d_ren_i && (id_reg_d_i == ex_reg_d_i);

    // r0 is hardwired zero, so a load targeting it produces nothing to wait for.
    assign load_use_o = ex_is_load_i && (ex_reg_d_i != '0) && (hit_j || hit_k || hit_d);

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: resolves load-use,
// divide, data-memory wait, mispredict and exception/ertn into stage controls.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_reg_j,
    input  logic [REG_W-1:0] id_reg_k,
    input  logic [REG_W-1:0] id_reg_d,
    input  logic             id_reg_j_ren,
    input  logic             id_reg_k_ren,
    input  logic             id_reg_d_ren,
    input  logic [REG_W-1:0] ex_reg_d,
    input  logic             ex_is_load,
    input  logic             ex_br_mispredict,
    input  logic [PC_W-1:0]  ex_br_target,
    input  logic             ex_div_start,
    input  logic             div_done,
    input  logic             mem_req_valid,
    input  logic             mem_data_ok,
    input  logic             wb_exc_valid,
    input  logic [PC_W-1:0]  wb_exc_entry,
    input  logic             wb_ertn,
    input  logic [PC_W-1:0]  wb_era,
    output logic             pc_wen,
    output logic             if_id_wen,
    output logic             if_id_flush,
    output logic             id_ex_wen,
    output logic             id_ex_flush,
    output logic             id_ex_bp_flush,
    output logic             ex_mem_wen,
    output logic             ex_mem_flush,
    output logic             mem_wb_wen,
    output logic             mem_wb_flush,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES - 1);

    ctrl_state_e        state_q, state_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    ctrl_out_t       ctl;
    logic            load_use;
    logic            exc_evt;
    logic [PC_W-1:0] exc_pc;

    pipe_hazard_detect u_hazard (
        .ex_is_load_i   (ex_is_load),
        .ex_reg_d_i     (ex_reg_d),
        .id_reg_j_i     (id_reg_j),
        .id_reg_k_i     (id_reg_k),
        .id_reg_d_i     (id_reg_d),
        .id_reg_j_ren_i (id_reg_j_ren),
        .id_reg_k_ren_i (id_reg_k_ren),
        .id_reg_d_ren_i (id_reg_d_ren),
        .load_use_o     (load_use)
    );

    assign exc_evt = wb_exc_valid || wb_ertn;
    // An exception outranks an ertn retiring in the same slot.
    assign exc_pc  = wb_exc_valid ? wb_exc_entry : wb_era;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        ctl         = CTL_RUN;

        case (state_q)
            ST_RUN: begin
                if (exc_evt) begin
                    ctl         = with_redirect(CTL_EXC, exc_pc);
                    state_d     = ST_EXC_DRAIN;
                    drain_cnt_d = DRAIN_INIT;
                end else if (mem_req_valid && !mem_data_ok) begin
                    ctl     = CTL_IDLE;
                    state_d = ST_MEM_WAIT;
                end else if (ex_div_start) begin
                    ctl     = CTL_DIV;
                    state_d = ST_DIV_WAIT;
                end else if (ex_br_mispredict) begin
                    ctl = with_redirect(CTL_MISPREDICT, ex_br_target);
                end else if (load_use) begin
                    ctl = CTL_LOAD_USE;
                end
            end

            // WB is frozen here, so a pending exception simply waits for the release.
            ST_MEM_WAIT: begin
                if (mem_data_ok) begin
                    state_d = ST_RUN;
                end else begin
                    ctl = CTL_IDLE;
                end
            end

            ST_DIV_WAIT: begin
                if (exc_evt) begin
                    ctl         = with_redirect(CTL_EXC, exc_pc);
                    state_d     = ST_EXC_DRAIN;
                    drain_cnt_d = DRAIN_INIT;
                end else if (div_done) begin
                    state_d = ST_RUN;
                end else begin
                    ctl = CTL_DIV;
                end
            end

            ST_EXC_DRAIN: begin
                ctl = CTL_DRAIN;
                if (drain_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Outputs are combinational, so reset must silence them directly.
        if (!rst_n) begin
            ctl = CTL_IDLE;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!ctl.pc_wen && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pc_wen         = ctl.pc_wen;
    assign if_id_wen      = ctl.if_id.wen;
    assign if_id_flush    = ctl.if_id.flush;
    assign id_ex_wen      = ctl.id_ex.wen;
    assign id_ex_flush    = ctl.id_ex.flush;
    assign id_ex_bp_flush = ctl.id_ex_bp_flush;
    assign ex_mem_wen     = ctl.ex_mem.wen;
    assign ex_mem_flush   = ctl.ex_mem.flush;
    assign mem_wb_wen     = ctl.mem_wb.wen;
    assign mem_wb_flush   = ctl.mem_wb.flush;
    assign redirect_valid = ctl.redirect_valid;
    assign redirect_pc    = ctl.redirect_pc;
    assign stall_cnt      = stall_cnt_q;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline. Drives the wen/flush(/bp_flush) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers, plus the PC write enable and front-end redirect.
- Resolves, in one place: load-use hazards, multi-cycle divide, data-memory wait, branch mispredict and exception/ertn.
- Small FSM plus a drain counter and a stall-cycle performance counter.

Parameters:
DRAIN_CYCLES, 2, cycles IF/ID stays flushed after exception/ertn redirect (>=1)
CNT_W, 32, width of stall_cnt

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous assert, active-low
id_reg_j / id_reg_k / id_reg_d  in  5 each  ID source register numbers
id_reg_j_ren / id_reg_k_ren / id_reg_d_ren  in  1 each  ID reads that register
ex_reg_d  in  5  EX destination register
ex_is_load  in  1  EX holds a load
ex_br_mispredict  in  1  EX branch resolved opposite to prediction
ex_br_target  in  32  correct PC for mispredict
ex_div_start  in  1  EX issues multi-cycle div/mod
div_done  in  1  divider result valid (1-cycle pulse)
mem_req_valid  in  1  MEM has outstanding data access
mem_data_ok  in  1  data access complete this cycle
wb_exc_valid  in  1  WB instruction raises exception
wb_exc_entry  in  32  exception entry PC
wb_ertn  in  1  WB is ertn
wb_era  in  32  return PC for ertn
pc_wen  out  1  PC register update enable
if_id_wen, if_id_flush  out  1 each  IF/ID control
id_ex_wen, id_ex_flush, id_ex_bp_flush  out  1 each  ID/EX control
ex_mem_wen, ex_mem_flush  out  1 each  EX/MEM control
mem_wb_wen, mem_wb_flush  out  1 each  MEM/WB control
redirect_valid  out  1  front end loads redirect_pc
redirect_pc  out  32  redirect target
stall_cnt  out  CNT_W  cycles with pc_wen=0

Behaviour:
- Stage-register semantics: wen=0 holds; wen=1 with flush=1 inserts a bubble.
- Control outputs are combinational from state + inputs; state, drain_cnt and stall_cnt are registered.
- Reset (rst_n=0, async): state=RUN, drain_cnt=0, stall_cnt=0.
  - During reset all wen/flush/bp_flush=0, redirect_valid=0, redirect_pc=0.
- Default (RUN, no event): all wen=1, all flush=0.
- States: RUN, MEM_WAIT, DIV_WAIT, EXC_DRAIN.
- RUN, priority high→low:
  1. wb_exc_valid|wb_ertn:
     - redirect_valid=1; redirect_pc=wb_exc_entry, or wb_era if only wb_ertn (exc wins if both).
     - All four stage registers wen=1, flush=1; pc_wen=1.
     - Next state EXC_DRAIN, drain_cnt=DRAIN_CYCLES-1.
  2. mem_req_valid & !mem_data_ok:
     - All wen=0, pc_wen=0; next state MEM_WAIT.
  3. ex_div_start:
     - pc_wen, if_id_wen, id_ex_wen, ex_mem_wen = 0.
     - mem_wb_wen=1 with mem_wb_flush=1.
     - Next state DIV_WAIT.
  4. ex_br_mispredict:
     - redirect_valid=1, redirect_pc=ex_br_target.
     - if_id_flush=1, id_ex_flush=1, id_ex_bp_flush=1; all wen=1.
     - Any load-use condition is ignored (wrong path).
  5. Load-use: ex_is_load & ex_reg_d!=0 & ((id_reg_j_ren & id_reg_j==ex_reg_d) | (id_reg_k_ren & id_reg_k==ex_reg_d) | (id_reg_d_ren & id_reg_d==ex_reg_d)):
     - pc_wen=0, if_id_wen=0.
     - id_ex_wen=1 with id_ex_flush=1; ex_mem and mem_wb advance normally.
- MEM_WAIT:
  - All wen=0 until mem_data_ok.
  - Exceptions are deferred; the WB instruction is frozen, so wb_exc stays asserted.
  - Cycle of mem_data_ok: outputs as RUN default; state→RUN. RUN priorities apply the next cycle.
- DIV_WAIT:
  - Freeze as in RUN item 3 until div_done.
  - wb_exc_valid|wb_ertn here: handled exactly as RUN item 1, divider result abandoned, state→EXC_DRAIN.
  - Cycle of div_done: all wen=1, no flush; state→RUN.
- EXC_DRAIN:
  - if_id_wen=1, if_id_flush=1; other wen=1, flush=0; pc_wen=1; no redirect.
  - drain_cnt decrements; state→RUN when drain_cnt==0 at clock edge.
  - New wb_exc/ertn in this state is ignored (pipeline empty by construction).
- stall_cnt: +1 every cycle pc_wen=0 (not in reset); saturates at all-ones.
- Register r0: never a hazard source.

Decomposition:
- Shared defs package: state encoding (RUN=2'd0, MEM_WAIT=2'd1, DIV_WAIT=2'd2, EXC_DRAIN=2'd3) and default DRAIN_CYCLES.
- One combinational sub-module, pipe_hazard_detect: load-use compare, output load_use.
- FSM, counters and output muxing stay in pipe_ctrl.

Test Plan:
- Load-use: ex_is_load=1, ex_reg_d=5, id_reg_k=5, id_reg_k_ren=1 → one cycle pc_wen=0, if_id_wen=0, id_ex_flush=1; stall_cnt +1. Same with ex_reg_d=0 → no stall.
- Mispredict: ex_br_mispredict=1, target 0x1c000040 → redirect_valid=1, redirect_pc=0x1c000040, if_id_flush=id_ex_flush=id_ex_bp_flush=1, pc_wen=1.
- Mem wait: mem_req_valid=1, mem_data_ok low 3 cycles → all wen=0 for 3 cycles; wb_exc_valid raised mid-wait has no effect until after data_ok; stall_cnt +3.
- Divide: ex_div_start, div_done after 8 cycles → 8 cycles of mem_wb bubble with front stages frozen; release cycle all wen=1.
- Exception during DIV_WAIT, wb_exc_entry=0x1c008000 → redirect to 0x1c008000, all four flushes=1, then if_id_flush=1 for exactly DRAIN_CYCLES=2 cycles, then RUN.
- ertn with wb_era=0x1c000100, plus async rst_n low mid EXC_DRAIN → after redirect, reset immediately drives all outputs 0, stall_cnt=0, state RUN after release.
